// File: rtl/seq_shift_unit.sv
// Multi-cycle shift/rotate register: one command per handshake, shifts the held word one bit per clock.
// Latency: LOAD/NOP/reserved/amt==0 -> done one cycle after accept; shift by n -> o final n edges after accept, done next cycle.
// Backpressure: cmd_ready is high only in IDLE; one command in flight, next accept no earlier than the cycle after DONE.
module seq_shift_unit #(
    parameter int unsigned     W         = 8,
    parameter logic [W-1:0]    RESET_VAL = '0,
    localparam int unsigned    AW        = $clog2(W)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          cmd_valid,
    output logic          cmd_ready,
    input  logic [2:0]    cmd_op,
    input  logic [AW-1:0] cmd_amt,
    input  logic [W-1:0]  load_data,
    output logic [W-1:0]  o,
    output logic          busy,
    output logic          done,
    output logic          err
);

    // Command opcodes as presented on cmd_op.
    localparam logic [2:0] OP_NOP  = 3'b000;
    localparam logic [2:0] OP_SLL  = 3'b001;
    localparam logic [2:0] OP_SRL  = 3'b010;
    localparam logic [2:0] OP_LOAD = 3'b011;
    localparam logic [2:0] OP_SRA  = 3'b100;
    localparam logic [2:0] OP_ROL  = 3'b101;
    localparam logic [2:0] OP_ROR  = 3'b110;
    localparam logic [2:0] OP_RSVD = 3'b111;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t          state;
    state_t          state_nxt;

    // Latched command and working registers.
    logic [2:0]      op_q;
    logic [2:0]      op_nxt;
    logic [AW-1:0]   cnt;
    logic [AW-1:0]   cnt_nxt;
    logic            err_q;
    logic            err_nxt;
    logic [W-1:0]    o_nxt;

    // Single one-bit step of the held word for the latched operation.
    function automatic logic [W-1:0] shift_step(input logic [W-1:0] v, input logic [2:0] op);
        logic [W-1:0] r;
        r = v;
        case (op)
            OP_SLL:  r = {v[W-2:0], 1'b0};
            OP_SRL:  r = {1'b0, v[W-1:1]};
            OP_SRA:  r = {v[W-1], v[W-1:1]};
            OP_ROL:  r = {v[W-2:0], v[W-1]};
            OP_ROR:  r = {v[0], v[W-1:1]};
            default: r = v;
        endcase
        return r;
    endfunction

    // True for the ops that walk through the SHIFT state.
    function automatic logic is_shift_op(input logic [2:0] op);
        return (op == OP_SLL) || (op == OP_SRL) || (op == OP_SRA) ||
               (op == OP_ROL) || (op == OP_ROR);
    endfunction

    // State register; reset aborts any command in flight without a done pulse.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state and next-datapath decode from the registered state and the accepted command.
    always_comb begin
        state_nxt = state;
        o_nxt     = o;
        cnt_nxt   = cnt;
        op_nxt    = op_q;
        err_nxt   = err_q;
        case (state)
            S_IDLE: begin
                // cmd_ready is high throughout IDLE, so valid alone means accept.
                if (cmd_valid) begin
                    op_nxt  = cmd_op;
                    err_nxt = 1'b0;
                    if (cmd_op == OP_LOAD) begin
                        o_nxt     = load_data;
                        state_nxt = S_DONE;
                    end else if (cmd_op == OP_RSVD) begin
                        err_nxt   = 1'b1;
                        state_nxt = S_DONE;
                    end else if (is_shift_op(cmd_op) && (cmd_amt != '0)) begin
                        cnt_nxt   = cmd_amt;
                        state_nxt = S_SHIFT;
                    end else begin
                        // NOP or a zero-distance shift: word is left untouched.
                        state_nxt = S_DONE;
                    end
                end
            end
            S_SHIFT: begin
                o_nxt   = shift_step(o, op_q);
                cnt_nxt = cnt - AW'(1);
                if (cnt == AW'(1)) begin
                    state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                // err is visible for the DONE cycle only; clear it on the way out.
                err_nxt   = 1'b0;
                state_nxt = S_IDLE;
            end
            default: begin
                state_nxt = S_IDLE;
                err_nxt   = 1'b0;
                cnt_nxt   = '0;
            end
        endcase
    end

    // Datapath registers: shift word, remaining count, latched op and error flag.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            o     <= RESET_VAL;
            cnt   <= '0;
            op_q  <= OP_NOP;
            err_q <= 1'b0;
        end else begin
            o     <= o_nxt;
            cnt   <= cnt_nxt;
            op_q  <= op_nxt;
            err_q <= err_nxt;
        end
    end

    // Status outputs decode registered state only; no input-to-output path.
    always_comb begin
        cmd_ready = (state == S_IDLE);
        busy      = (state == S_SHIFT);
        done      = (state == S_DONE);
        err       = (state == S_DONE) && err_q;
    end

endmodule

// File: tb/tb_seq_shift_unit.sv
// Bench for seq_shift_unit at W=8, RESET_VAL=0.
// Latency: inputs change and outputs are sampled 1 time unit after each rising edge.
// Backpressure: commands are only issued when cmd_ready is observed high.
module tb_seq_shift_unit;

    localparam int W = 8;

    logic         clk;
    logic         rst;
    logic         cmd_valid;
    logic         cmd_ready;
    logic [2:0]   cmd_op;
    logic [2:0]   cmd_amt;
    logic [W-1:0] load_data;
    logic [W-1:0] o;
    logic         busy;
    logic         done;
    logic         err;

    int n_cmp;
    int n_bad;

    seq_shift_unit #(.W(W), .RESET_VAL(8'h00)) dut (
        .clk       (clk),
        .rst       (rst),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_op    (cmd_op),
        .cmd_amt   (cmd_amt),
        .load_data (load_data),
        .o         (o),
        .busy      (busy),
        .done      (done),
        .err       (err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Reference: final word after a whole command, using plain whole-word arithmetic.
    function automatic logic [W-1:0] ref_result(input logic [2:0] op, input int amt,
                                                input logic [W-1:0] cur, input logic [W-1:0] data);
        logic [2*W-1:0] dbl;
        logic [W-1:0]   r;
        dbl = {cur, cur};
        case (op)
            3'd1: r = cur << amt;
            3'd2: r = cur >> amt;
            3'd3: r = data;
            3'd4: r = $signed(cur) >>> amt;
            3'd5: begin dbl = dbl << amt; r = dbl[2*W-1:W]; end
            3'd6: begin dbl = dbl >> amt; r = dbl[W-1:0]; end
            default: r = cur;
        endcase
        return r;
    endfunction

    // Reference: cycles spent in SHIFT (= cycles from accept to done).
    function automatic int ref_latency(input logic [2:0] op, input int amt);
        if ((op == 3'd1 || op == 3'd2 || op == 3'd4 || op == 3'd5 || op == 3'd6) && amt != 0)
            return amt;
        return 0;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Issue one command and follow it to its done cycle (returns positioned in that cycle).
    task automatic run_cmd(input logic [2:0] op, input int amt, input logic [W-1:0] data,
                           output int lat, output int busy_cyc, output logic err_seen);
        int guard;
        guard = 0;
        lat = 0;
        busy_cyc = 0;
        err_seen = 1'b0;
        while (!cmd_ready && guard < 50) begin
            step();
            guard++;
        end
        if (!cmd_ready) begin
            n_cmp++; n_bad++;
            $display("FAIL run_cmd_ready_timeout: cmd_ready=%b required 1", cmd_ready);
            return;
        end
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_amt   = 3'(amt);
        load_data = data;
        step();
        // Command inputs are don't-care after the accept edge; scramble them.
        cmd_valid = 1'b0;
        cmd_op    = 3'($urandom);
        cmd_amt   = 3'($urandom);
        load_data = 8'($urandom);
        while (!done && lat < 50) begin
            if (busy) busy_cyc++;
            step();
            lat++;
        end
        if (!done) begin
            n_cmp++; n_bad++;
            $display("FAIL run_cmd_done_timeout: done=%b required 1 within 50 cycles", done);
        end else begin
            err_seen = err;
        end
    endtask

    task automatic test_reset();
        #2 rst = 1'b1;
        #1;
        n_cmp++; if (o !== 8'h00)     begin n_bad++; $display("FAIL reset_o: got %h want 00", o); end
        n_cmp++; if (cmd_ready !== 1) begin n_bad++; $display("FAIL reset_ready: got %b want 1", cmd_ready); end
        n_cmp++; if (busy !== 0)      begin n_bad++; $display("FAIL reset_busy: got %b want 0", busy); end
        n_cmp++; if (done !== 0 || err !== 0) begin n_bad++; $display("FAIL reset_done_err: got %b%b want 00", done, err); end
        #4 rst = 1'b0;
        #1;
        n_cmp++; if (o !== 8'h00 || cmd_ready !== 1) begin n_bad++; $display("FAIL reset_release: o=%h rdy=%b want 00/1", o, cmd_ready); end
        step();
    endtask

    task automatic test_load_sll();
        int lat, bc;
        logic e;
        run_cmd(3'd3, 0, 8'hA5, lat, bc, e);
        n_cmp++; if (o !== 8'hA5 || lat != 0) begin n_bad++; $display("FAIL load_a5: o=%h lat=%0d want a5/0", o, lat); end
        step();
        run_cmd(3'd1, 3, 8'h00, lat, bc, e);
        n_cmp++; if (o !== ref_result(3'd1, 3, 8'hA5, 8'h00)) begin n_bad++; $display("FAIL sll3_o: got %h want %h", o, ref_result(3'd1, 3, 8'hA5, 8'h00)); end
        n_cmp++; if (bc != 3 || lat != 3) begin n_bad++; $display("FAIL sll3_busy: busy=%0d lat=%0d want 3/3", bc, lat); end
        n_cmp++; if (e !== 0) begin n_bad++; $display("FAIL sll3_err: got %b want 0", e); end
        step();
        n_cmp++; if (done !== 0 || cmd_ready !== 1) begin n_bad++; $display("FAIL sll3_after: done=%b rdy=%b want 0/1", done, cmd_ready); end
    endtask

    task automatic test_modes();
        logic [2:0] ops [5]  = '{3'd4, 3'd2, 3'd6, 3'd5, 3'd1};
        int         amts [5] = '{2, 2, 4, 1, 0};
        logic [7:0] seed [5] = '{8'h96, 8'h96, 8'hA5, 8'h81, 8'h3C};
        logic [7:0] want [5] = '{8'hE5, 8'h25, 8'h5A, 8'h03, 8'h3C};
        int lat, bc;
        logic e;
        for (int i = 0; i < 5; i++) begin
            run_cmd(3'd3, 0, seed[i], lat, bc, e);
            step();
            run_cmd(ops[i], amts[i], 8'h00, lat, bc, e);
            n_cmp++;
            if (o !== want[i] || lat != amts[i]) begin
                n_bad++;
                $display("FAIL mode_%0d: op=%0d o=%h lat=%0d want %h/%0d", i, ops[i], o, lat, want[i], amts[i]);
            end
            step();
        end
    endtask

    task automatic test_reserved();
        int lat, bc;
        logic e;
        run_cmd(3'd3, 0, 8'h6D, lat, bc, e);
        step();
        run_cmd(3'd7, 5, 8'hFF, lat, bc, e);
        n_cmp++; if (e !== 1 || done !== 1 || lat != 0) begin n_bad++; $display("FAIL rsvd_err: err=%b done=%b lat=%0d want 1/1/0", e, done, lat); end
        n_cmp++; if (o !== 8'h6D) begin n_bad++; $display("FAIL rsvd_o: got %h want 6d", o); end
        step();
        n_cmp++; if (err !== 0 || done !== 0) begin n_bad++; $display("FAIL rsvd_pulse: err=%b done=%b want 0/0", err, done); end
    endtask

    task automatic test_back_to_back();
        int lat, bc;
        logic e;
        int acc_cyc [$];
        int done_cnt;
        logic [7:0] v;
        v = 8'h5B;
        run_cmd(3'd3, 0, v, lat, bc, e);
        step();
        done_cnt = 0;
        cmd_valid = 1'b1;
        cmd_op    = 3'd1;
        cmd_amt   = 3'd1;
        for (int k = 0; k < 9; k++) begin
            if (cmd_valid && cmd_ready) acc_cyc.push_back(k);
            if (done) done_cnt++;
            step();
            if (acc_cyc.size() == 2) cmd_valid = 1'b0;
        end
        n_cmp++;
        if (acc_cyc.size() != 2) begin
            n_bad++;
            $display("FAIL b2b_accepts: got %0d accepts want 2", acc_cyc.size());
        end else if (acc_cyc[1] - acc_cyc[0] != 1 + 2) begin
            n_bad++;
            $display("FAIL b2b_gap: got %0d cycles want 3", acc_cyc[1] - acc_cyc[0]);
        end
        n_cmp++; if (done_cnt != 2) begin n_bad++; $display("FAIL b2b_done: got %0d pulses want 2", done_cnt); end
        n_cmp++;
        if (o !== ref_result(3'd1, 1, ref_result(3'd1, 1, v, 8'h00), 8'h00)) begin
            n_bad++;
            $display("FAIL b2b_o: got %h want %h", o, ref_result(3'd1, 2, v, 8'h00));
        end
    endtask

    task automatic test_abort();
        int lat, bc;
        logic e;
        int seen_done;
        run_cmd(3'd3, 0, 8'hFF, lat, bc, e);
        step();
        cmd_valid = 1'b1;
        cmd_op    = 3'd2;
        cmd_amt   = 3'd7;
        step();
        cmd_valid = 1'b0;
        step(); step(); step();
        n_cmp++; if (o !== ref_result(3'd2, 3, 8'hFF, 8'h00) || busy !== 1) begin n_bad++; $display("FAIL abort_mid: o=%h busy=%b want 1f/1", o, busy); end
        #3 rst = 1'b1;
        #1;
        n_cmp++; if (o !== 8'h00 || busy !== 0 || done !== 0 || cmd_ready !== 1) begin
            n_bad++; $display("FAIL abort_reset: o=%h busy=%b done=%b rdy=%b want 00/0/0/1", o, busy, done, cmd_ready);
        end
        #2 rst = 1'b0;
        seen_done = 0;
        for (int k = 0; k < 10; k++) begin
            step();
            if (done) seen_done++;
        end
        n_cmp++; if (seen_done != 0) begin n_bad++; $display("FAIL abort_no_done: got %0d pulses want 0", seen_done); end
        run_cmd(3'd3, 0, 8'h3C, lat, bc, e);
        n_cmp++; if (o !== 8'h3C || lat != 0) begin n_bad++; $display("FAIL abort_next: o=%h lat=%0d want 3c/0", o, lat); end
        step();
    endtask

    task automatic test_random();
        int lat, bc;
        logic e;
        logic [2:0] op;
        int amt;
        logic [7:0] data;
        logic [7:0] model_o;
        model_o = o;
        for (int i = 0; i < 60; i++) begin
            op   = 3'($urandom_range(7, 0));
            amt  = int'($urandom_range(7, 0));
            data = 8'($urandom);
            run_cmd(op, amt, data, lat, bc, e);
            model_o = ref_result(op, amt, model_o, data);
            n_cmp++;
            if (o !== model_o || lat != ref_latency(op, amt) || bc != ref_latency(op, amt) || e !== (op == 3'd7)) begin
                n_bad++;
                $display("FAIL rand_%0d: op=%0d amt=%0d o=%h lat=%0d busy=%0d err=%b want %h/%0d/%0d/%b",
                         i, op, amt, o, lat, bc, e, model_o, ref_latency(op, amt), ref_latency(op, amt), op == 3'd7);
            end
            step();
            n_cmp++;
            if (done !== 0 || err !== 0 || cmd_ready !== 1) begin
                n_bad++;
                $display("FAIL rand_after_%0d: done=%b err=%b rdy=%b want 0/0/1", i, done, err, cmd_ready);
            end
        end
    endtask

    initial begin
        n_cmp     = 0;
        n_bad     = 0;
        rst       = 1'b0;
        cmd_valid = 1'b0;
        cmd_op    = 3'd0;
        cmd_amt   = 3'd0;
        load_data = 8'h00;
        test_reset();
        test_load_sll();
        test_modes();
        test_reserved();
        test_back_to_back();
        test_abort();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
